// File: rtl/jogador_automatico.sv
// Automatic player for circuito_jogo_base: pulses iniciar, then plays
// a fixed 16-move sequence on botoes and latches the game result.
module jogador_automatico #(
   parameter int INICIAR_CICLOS = 5,
   parameter int ESPERA_CICLOS  = 10,
   parameter int PRESS_CICLOS   = 10,
   parameter int SOLTA_CICLOS   = 10,
   parameter int TIMEOUT_CICLOS = 1000,
   parameter int CONT_W         = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       comecar,
   input  logic       injeta_erro,
   input  logic [3:0] indice_erro,
   input  logic       pronto,
   input  logic       acertou,
   input  logic       errou,
   output logic       iniciar,
   output logic [3:0] botoes,
   output logic       ocupado,
   output logic       fim_acerto,
   output logic       fim_erro,
   output logic       fim_timeout,
   output logic [3:0] db_indice,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      OCIOSO    = 4'd0,
      PULSO_INI = 4'd1,
      ESPERA    = 4'd2,
      PRESSIONA = 4'd3,
      SOLTA     = 4'd4,
      AGUARDA   = 4'd5,
      FIM       = 4'd6
   } estado_t;

   // Last counter value of a state; a zero length behaves as one cycle.
   function automatic logic [CONT_W-1:0] lim(input int p);
      return (p <= 1) ? '0 : CONT_W'(p - 1);
   endfunction

   localparam logic [CONT_W-1:0] LIM_INI = lim(INICIAR_CICLOS);
   localparam logic [CONT_W-1:0] LIM_ESP = lim(ESPERA_CICLOS);
   localparam logic [CONT_W-1:0] LIM_PRS = lim(PRESS_CICLOS);
   localparam logic [CONT_W-1:0] LIM_SLT = lim(SOLTA_CICLOS);
   localparam logic [CONT_W-1:0] LIM_TO  = lim(TIMEOUT_CICLOS);

   // Move k lives in bits [4k+3:4k].
   localparam logic [63:0] ROM = {
      4'b0100, 4'b0001, 4'b1000, 4'b1000,
      4'b0100, 4'b0100, 4'b0010, 4'b0010,
      4'b0001, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0100, 4'b0010, 4'b0001
   };

   estado_t           estado_q, estado_d;
   logic [CONT_W-1:0] cnt_q, cnt_d;
   logic [3:0]        indice_q, indice_d;
   logic              iniciar_q, iniciar_d;
   logic [3:0]        botoes_q, botoes_d;
   logic              ocupado_q, ocupado_d;
   logic              fa_q, fa_d;
   logic              fe_q, fe_d;
   logic              ft_q, ft_d;
   logic [3:0]        jogada;
   logic [5:0]        ptr;

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q + 1'b1;
      indice_d = indice_q;
      fa_d     = fa_q;
      fe_d     = fe_q;
      ft_d     = ft_q;
      unique case (estado_q)
         OCIOSO: begin
            cnt_d = '0;
            fa_d  = 1'b0;
            fe_d  = 1'b0;
            ft_d  = 1'b0;
            if (comecar) begin
               estado_d = PULSO_INI;
               indice_d = '0;
            end
         end
         PULSO_INI: if (cnt_q == LIM_INI) estado_d = ESPERA;
         ESPERA:    if (cnt_q == LIM_ESP) estado_d = PRESSIONA;
         PRESSIONA: if (cnt_q == LIM_PRS) estado_d = SOLTA;
         SOLTA: begin
            if (cnt_q == LIM_SLT) begin
               if (indice_q == 4'd15) begin
                  estado_d = AGUARDA;
               end else begin
                  estado_d = PRESSIONA;
                  indice_d = indice_q + 4'd1;
               end
            end
         end
         AGUARDA: begin
            if (cnt_q == LIM_TO) begin
               estado_d = FIM;
               ft_d     = 1'b1;
            end
         end
         FIM: begin
            cnt_d = '0;
            if (comecar) begin
               estado_d = PULSO_INI;
               indice_d = '0;
               fa_d     = 1'b0;
               fe_d     = 1'b0;
               ft_d     = 1'b0;
            end
         end
         default: estado_d = OCIOSO;
      endcase
      // A result from the core overrides any counter expiry.
      if (pronto && (estado_q inside {ESPERA, PRESSIONA, SOLTA, AGUARDA})) begin
         estado_d = FIM;
         indice_d = indice_q;
         fa_d     = acertou;
         fe_d     = errou;
         ft_d     = 1'b0;
      end
      if (estado_d != estado_q) cnt_d = '0;
   end

   always_comb begin
      ptr    = {indice_d, 2'b00};
      jogada = ROM[ptr +: 4];
      if (injeta_erro && (indice_d == indice_erro)) begin
         jogada = {jogada[2:0], jogada[3]};
      end
      iniciar_d = (estado_d == PULSO_INI);
      ocupado_d = !(estado_d inside {OCIOSO, FIM});
      botoes_d  = '0;
      if (estado_d == PRESSIONA) begin
         botoes_d = (estado_q == PRESSIONA) ? botoes_q : jogada;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q  <= OCIOSO;
         cnt_q     <= '0;
         indice_q  <= '0;
         iniciar_q <= 1'b0;
         botoes_q  <= '0;
         ocupado_q <= 1'b0;
         fa_q      <= 1'b0;
         fe_q      <= 1'b0;
         ft_q      <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         indice_q  <= indice_d;
         iniciar_q <= iniciar_d;
         botoes_q  <= botoes_d;
         ocupado_q <= ocupado_d;
         fa_q      <= fa_d;
         fe_q      <= fe_d;
         ft_q      <= ft_d;
      end
   end

   assign iniciar     = iniciar_q;
   assign botoes      = botoes_q;
   assign ocupado     = ocupado_q;
   assign fim_acerto  = fa_q;
   assign fim_erro    = fe_q;
   assign fim_timeout = ft_q;
   assign db_indice   = indice_q;
   assign db_estado   = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: each game's expected trace is derived
// arithmetically from the cycle number since the start request.
module tb_jogador_automatico;

   localparam int N_INI = 5;
   localparam int N_ESP = 10;
   localparam int N_PRS = 10;
   localparam int N_SLT = 10;
   localparam int N_TO  = 1000;
   localparam int T_MOV = N_INI + N_ESP;
   localparam int T_AGU = T_MOV + 16 * (N_PRS + N_SLT);
   localparam int T_TO  = T_AGU + N_TO;

   logic       clock = 1'b0;
   logic       reset;
   logic       comecar;
   logic       injeta_erro;
   logic [3:0] indice_erro;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic       iniciar;
   logic [3:0] botoes;
   logic       ocupado;
   logic       fim_acerto;
   logic       fim_erro;
   logic       fim_timeout;
   logic [3:0] db_indice;
   logic [3:0] db_estado;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] seq [16] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0100, 4'b0010, 4'b0001, 4'b0001,
      4'b0010, 4'b0010, 4'b0100, 4'b0100,
      4'b1000, 4'b1000, 4'b0001, 4'b0100
   };

   jogador_automatico #(
      .INICIAR_CICLOS(N_INI),
      .ESPERA_CICLOS (N_ESP),
      .PRESS_CICLOS  (N_PRS),
      .SOLTA_CICLOS  (N_SLT),
      .TIMEOUT_CICLOS(N_TO),
      .CONT_W        (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .comecar    (comecar),
      .injeta_erro(injeta_erro),
      .indice_erro(indice_erro),
      .pronto     (pronto),
      .acertou    (acertou),
      .errou      (errou),
      .iniciar    (iniciar),
      .botoes     (botoes),
      .ocupado    (ocupado),
      .fim_acerto (fim_acerto),
      .fim_erro   (fim_erro),
      .fim_timeout(fim_timeout),
      .db_indice  (db_indice),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   function automatic logic [17:0] obs();
      return {iniciar, botoes, ocupado, fim_acerto, fim_erro,
              fim_timeout, db_indice, db_estado};
   endfunction

   function automatic int fim_de(int tp);
      return (tp >= N_INI && tp < T_TO) ? tp + 1 : T_TO;
   endfunction

   function automatic int idx_de(int t);
      if (t < T_MOV) return 0;
      if (t < T_AGU) return (t - T_MOV) / (N_PRS + N_SLT);
      return 15;
   endfunction

   // Expected outputs in cycle t after the start edge.
   function automatic logic [17:0] modelo(int t, int tp, bit ac, bit er,
                                          bit inj, int ie);
      int fin, k, r, est;
      bit ini, oc, fa, fe, ft;
      logic [3:0] b, m;
      fin = fim_de(tp);
      ini = 0; oc = 0; fa = 0; fe = 0; ft = 0; b = 0; est = 0;
      if (t >= fin) begin
         est = 6;
         if (fin == T_TO && tp != T_TO - 1) ft = 1;
         else begin fa = ac; fe = er; end
         k = idx_de(fin - 1);
      end else begin
         oc = 1;
         k  = idx_de(t);
         if (t < N_INI) begin
            est = 1; ini = 1;
         end else if (t < T_MOV) begin
            est = 2;
         end else if (t < T_AGU) begin
            r = (t - T_MOV) % (N_PRS + N_SLT);
            if (r < N_PRS) begin
               est = 3;
               m = seq[k];
               if (inj && k == ie) m = {m[2:0], m[3]};
               b = m;
            end else est = 4;
         end else est = 5;
      end
      return {ini, b, oc, fa, fe, ft, 4'(k), 4'(est)};
   endfunction

   task automatic confere(string tag, logic [17:0] got, logic [17:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic passo();
      @(posedge clock);
      #1;
   endtask

   task automatic jogo(int g, int tp, bit ac, bit er, bit inj, int ie,
                       int rst_at, int w);
      int fin;
      fin = fim_de(tp);
      if (tp == T_TO - 1) fin = T_TO;
      injeta_erro = inj;
      indice_erro = 4'(ie);
      pronto = 0; acertou = 0; errou = 0;
      comecar = 1;
      passo();
      comecar = 0;
      for (int t = 0; t <= fin + w; t++) begin
         confere($sformatf("g%0d t%0d", g, t), obs(),
                 modelo(t, tp, ac, er, inj, ie));
         if (t == rst_at) begin
            reset = 1;
            passo();
            reset = 0;
            confere($sformatf("g%0d rst", g), obs(), '0);
            return;
         end
         if (t == tp) begin
            pronto = 1; acertou = ac; errou = er;
         end else begin
            pronto  = (t < N_INI || t >= fin) ? 1'($urandom % 2) : 1'b0;
            acertou = 1'($urandom % 2);
            errou   = 1'($urandom % 2);
         end
         comecar = (t < fin) ? 1'($urandom % 2) : 1'b0;
         if (t < fin + w) passo();
      end
   endtask

   initial begin
      reset = 1; comecar = 0; injeta_erro = 0; indice_erro = 0;
      pronto = 0; acertou = 0; errou = 0;
      repeat (2) passo();
      confere("reset", obs(), '0);
      reset = 0;
      repeat (2) begin
         passo();
         confere("idle", obs(), '0);
      end
      jogo(1, T_AGU - 1, 1, 0, 0, 0, -1, 2);
      jogo(2, T_MOV + 4 * 20 + 13, 0, 1, 1, 4, -1, 0);
      jogo(3, T_MOV + 2, 1, 0, 0, 0, -1, 1);
      jogo(4, -1, 0, 0, 0, 0, -1, 3);
      jogo(5, T_TO - 1, 1, 1, 0, 0, -1, 1);
      jogo(6, -1, 0, 0, 1, 7, T_MOV + 7 * 20 + 3, 0);
      jogo(7, N_INI, 0, 1, 0, 0, -1, 0);
      jogo(8, T_MOV + 15 * 20 + 5, 0, 1, 1, 15, -1, 2);
      jogo(9, T_MOV + 3 * 20 + 12, 1, 0, 1, 3, -1, 1);
      for (int g = 10; g < 18; g++) begin
         jogo(g, int'($urandom_range(N_INI, T_TO + 50)),
              1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
              int'($urandom % 16),
              ($urandom % 4 == 0) ? int'($urandom_range(1, 300)) : -1,
              int'($urandom % 4));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Hardware auto-player for circuito_jogo_base: the button-pressing end of the game interface, normally played by a human or a testbench.
- On a start request it pulses iniciar, then plays a fixed 16-move sequence on botoes with programmable press and release times, while monitoring pronto, acertou and errou.
- It can deliberately miss one chosen move to exercise the error path.
- It sits beside the game core on the FPGA as a self-test source, with a board switch selecting whether the player or the real buttons drive botoes (mux lives outside this block).

Parameters:
- INICIAR_CICLOS, 5, cycles iniciar is held high.
- ESPERA_CICLOS, 10, idle cycles after iniciar falls, before the first move.
- PRESS_CICLOS, 10, cycles each move holds botoes nonzero.
- SOLTA_CICLOS, 10, cycles botoes stays 0 after each move.
- TIMEOUT_CICLOS, 1000, maximum cycles to wait for pronto after the last move.
- CONT_W, 16, width of the shared timing counter; every parameter value must be less than 2^CONT_W.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- comecar, in, 1: start request, level-sensitive, sampled in OCIOSO and FIM.
- injeta_erro, in, 1: when 1, move number indice_erro is played wrong.
- indice_erro, in, 4: index (0..15) of the move to corrupt.
- pronto, in, 1: from game core.
- acertou, in, 1: from game core.
- errou, in, 1: from game core.
- iniciar, out, 1: to game core iniciar.
- botoes, out, 4: to game core botoes, one-hot or 0.
- ocupado, out, 1: 1 in every state except OCIOSO and FIM.
- fim_acerto, out, 1: game ended with acertou.
- fim_erro, out, 1: game ended with errou.
- fim_timeout, out, 1: no pronto within TIMEOUT_CICLOS.
- db_indice, out, 4: current move index.
- db_estado, out, 4: state code.

Behaviour:
- All outputs are registered. On reset: state OCIOSO, all outputs 0, indice 0, counter 0. Reset in any state aborts immediately, including mid-press, so botoes is 0 on the next cycle.
- The move sequence is a fixed internal ROM, indices 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Wrong move: when injeta_erro=1 and indice==indice_erro, the ROM value is rotated left by 1 (1000 becomes 0001). injeta_erro and indice_erro are sampled on entry to PRESSIONA.
- States and codes:
  - OCIOSO (0): comecar=1 -> PULSO_INI. Counter is cleared and the fim_* flags are cleared.
  - PULSO_INI (1): iniciar=1 for exactly INICIAR_CICLOS cycles -> ESPERA.
  - ESPERA (2): ESPERA_CICLOS cycles with iniciar=0 and botoes=0 -> PRESSIONA.
  - PRESSIONA (3): botoes=move for exactly PRESS_CICLOS cycles -> SOLTA.
  - SOLTA (4): botoes=0 for SOLTA_CICLOS cycles. Then if indice==15 -> AGUARDA; otherwise indice+1 -> PRESSIONA.
  - AGUARDA (5): wait for pronto. Counter reaching TIMEOUT_CICLOS -> FIM with fim_timeout=1.
  - FIM (6): botoes=0, iniciar=0, fim_* flags held. comecar=1 -> PULSO_INI, clearing the flags and indice.
- Result monitoring: in ESPERA, PRESSIONA, SOLTA and AGUARDA, pronto=1 forces FIM on the next edge.
  - fim_acerto<=acertou and fim_erro<=errou, latched on that edge.
  - pronto takes priority over any counter expiry in the same cycle.
  - botoes drops to 0 on entry to FIM, even mid-press.
- Timing: the state counter resets to 0 on every state entry. The transition occurs on the edge where counter==PARAM-1. A parameter value of 0 is treated as 1.
- comecar held high continuously restarts a new game immediately after each FIM (one cycle in FIM).
- iniciar and botoes are never nonzero in the same cycle.

Test Plan:
1. Reset, comecar pulse, injeta_erro=0, game core returns pronto+acertou after the 16th release:
   - iniciar high for 5 cycles starting 1 cycle after comecar.
   - botoes shows 0001 for 10 cycles starting 11 cycles after iniciar falls, then 0 for 10 cycles, then 0010, and so on through the 16 ROM values.
   - Ends in FIM with fim_acerto=1, ocupado=0, db_indice=15.
2. injeta_erro=1, indice_erro=4:
   - Moves 0..3 match the ROM; move 4 drives 1000 instead of 0100.
   - Core raises pronto+errou during the release -> FIM next edge, fim_erro=1, db_indice=4, no further presses.
3. pronto+acertou asserted during the 3rd cycle of PRESSIONA:
   - botoes=0 on the next cycle, state FIM (db_estado=6), fim_acerto=1.
4. Full sequence played, core never raises pronto:
   - Exactly TIMEOUT_CICLOS cycles in AGUARDA, then fim_timeout=1 with fim_acerto=fim_erro=0.
5. Reset asserted for 1 cycle mid-PRESSIONA at move 7:
   - Next cycle all outputs 0, db_estado=0, db_indice=0.
   - A following comecar replays from move 0.
6. From FIM, pulse comecar:
   - fim_* flags clear on the transition edge, iniciar pulses again, and the sequence restarts at index 0.
